// File: rtl/camera_capture_ctrl.sv
// Single-frame camera capture sequencer: RGB565 byte pairs -> 16-bit pixels at linear frame-buffer addresses.
// Optional continuous capture while the shutter is held: define CAPTURE_CONTINUOUS_EN.
`timescale 1ns/1ps
module camera_capture_ctrl #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shutter,
    input  logic              href,
    input  logic              vsync,
    input  logic [7:0]        data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int BYTES_PER_LINE = 2 * H_PIXELS;
    localparam int BCNT_W = $clog2(BYTES_PER_LINE + 2);
    localparam int LCNT_W = $clog2(V_LINES + 1);
    localparam logic [BCNT_W-1:0] LINE_BYTES = BCNT_W'(BYTES_PER_LINE);
    localparam logic [BCNT_W-1:0] BCNT_MAX   = BCNT_W'(BYTES_PER_LINE + 1);
    localparam logic [LCNT_W-1:0] LINES      = LCNT_W'(V_LINES);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_PIXELS * V_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_VBLANK  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q;
    logic [2:0]          sh_sync_q;
    logic                vsync_q;
    logic                href_q;
    logic                phase_q;
    logic [7:0]          hi_byte_q;
    logic [BCNT_W-1:0]   byte_cnt_q;
    logic [LCNT_W-1:0]   line_cnt_q;
    logic                full_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [15:0]         wr_data_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                frame_err_q;

    logic                sh_rise;
    logic                vs_rise;
    logic                vs_fall;
    logic                href_fall;
    logic [LCNT_W-1:0]   line_cnt_d;
    logic                line_bad;
    logic                frame_end;
    logic                short_frame;

    // A line that closes together with a vsync rise is counted before the frame-end decision.
    assign sh_rise     = sh_sync_q[1] & ~sh_sync_q[2];
    assign vs_rise     = vsync & ~vsync_q;
    assign vs_fall     = ~vsync & vsync_q;
    assign href_fall   = href_q & ~href;
    assign line_cnt_d  = href_fall ? (line_cnt_q + LCNT_W'(1)) : line_cnt_q;
    assign line_bad    = href_fall & (byte_cnt_q != LINE_BYTES);
    assign frame_end   = (line_cnt_d == LINES) | vs_rise;
    assign short_frame = vs_rise & (line_cnt_d < LINES);

    // Capture sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sh_sync_q    <= 3'b000;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            hi_byte_q    <= 8'h00;
            byte_cnt_q   <= '0;
            line_cnt_q   <= '0;
            full_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 16'h0000;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sh_sync_q    <= {sh_sync_q[1:0], shutter};
            vsync_q      <= vsync;
            href_q       <= href;
            frame_done_q <= 1'b0;
            wr_en_q      <= 1'b0;
            // Address saturates at the last pixel; full_q then blocks further writes.
            if (wr_en_q) begin
                if (wr_addr_q == LAST_ADDR) begin
                    full_q <= 1'b1;
                end else begin
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (sh_rise) begin
                        state_q     <= S_ARM;
                        busy_q      <= 1'b1;
                        frame_err_q <= 1'b0;
                        wr_addr_q   <= '0;
                        full_q      <= 1'b0;
                        line_cnt_q  <= '0;
                        byte_cnt_q  <= '0;
                        phase_q     <= 1'b0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (vsync) begin
                        state_q <= S_VBLANK;
                    end
                end
                S_VBLANK: begin
                    if (vs_fall) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (href) begin
                        phase_q <= ~phase_q;
                        if (byte_cnt_q != BCNT_MAX) begin
                            byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                        end
                        if (!phase_q) begin
                            hi_byte_q <= data;
                        end else if (full_q) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= {hi_byte_q, data};
                        end
                    end else if (href_fall) begin
                        phase_q    <= 1'b0;
                        byte_cnt_q <= '0;
                        line_cnt_q <= line_cnt_d;
                        if (line_bad) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    if (frame_end) begin
                        state_q      <= S_DONE;
                        frame_done_q <= 1'b1;
                        if (short_frame) begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
`ifdef CAPTURE_CONTINUOUS_EN
                    if (sh_sync_q[1]) begin
                        state_q     <= S_VBLANK;
                        frame_err_q <= 1'b0;
                        wr_addr_q   <= '0;
                        full_q      <= 1'b0;
                        line_cnt_q  <= '0;
                        byte_cnt_q  <= '0;
                        phase_q     <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Randomized bench for camera_capture_ctrl (H_PIXELS=4, V_LINES=2) against a frame-level reference model.
`timescale 1ns/1ps
module tb_camera_capture_ctrl;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int AW  = 3;
    localparam int N   = H * V;
    localparam int BPL = 2 * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          shutter;
    logic          href;
    logic          vsync;
    logic [7:0]    data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          frame_done;
    logic          frame_err;

    camera_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .shutter(shutter), .href(href), .vsync(vsync), .data(data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #20 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write/pulse monitor, sampled away from the active edge.
    logic [AW-1:0] mon_addr[$];
    logic [15:0]   mon_data[$];
    int            done_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                mon_addr.push_back(wr_addr);
                mon_data.push_back(wr_data);
            end
            if (frame_done) done_cnt++;
        end
    end

    // Frame description
    int         f_nlines;
    int         f_len[V];
    logic [7:0] f_byte[V][BPL+4];
    bit         f_sim_vs;
    int         f_sh_at;
    logic       f_sh_val;
    int         f_reset_after;

    // Expected results
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];
    logic          exp_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int nlines, input int len0, input int len1, input int base);
        f_nlines = nlines;
        f_len[0] = len0;
        f_len[1] = len1;
        for (int l = 0; l < V; l++)
            for (int b = 0; b < BPL + 4; b++)
                f_byte[l][b] = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + l * 16 + b + 1);
        f_sim_vs = 1'b0;
        f_sh_at = -1;
        f_sh_val = 1'b0;
        f_reset_after = -1;
    endtask

    // Pixels are consecutive byte pairs of each line, placed at consecutive addresses until the buffer is full.
    task automatic compute_expected();
        int addr;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        addr = 0;
        for (int l = 0; l < f_nlines; l++) begin
            for (int p = 0; p < f_len[l] / 2; p++) begin
                if (addr < N) begin
                    exp_addr.push_back(AW'(addr));
                    exp_data.push_back({f_byte[l][2*p], f_byte[l][2*p+1]});
                    addr++;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (f_len[l] != BPL) exp_err = 1'b1;
        end
        if (f_nlines < V) exp_err = 1'b1;
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        done_cnt = 0;
    endtask

    task automatic arm(input bit hold);
        shutter = 1'b0;
        repeat (3) tick();
        shutter = 1'b1;
        repeat (5) tick();
        check("busy_after_arm", busy, 1'b1);
        if (!hold) shutter = 1'b0;
    endtask

    task automatic drive_frame();
        bit did_reset = 1'b0;
        vsync = 1'b1;
        href = 1'b0;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < f_nlines; l++) begin
            for (int b = 0; b < f_len[l]; b++) begin
                href = 1'b1;
                data = f_byte[l][b];
                if (l == 0 && b == f_sh_at) shutter = f_sh_val;
                if (f_reset_after >= 0 && !did_reset && mon_addr.size() == f_reset_after) begin
                    reset = 1'b1;
                    did_reset = 1'b1;
                    #1;
                    check("rst_wr_en", wr_en, 1'b0);
                    check("rst_wr_addr", wr_addr, 0);
                    check("rst_wr_data", wr_data, 0);
                    check("rst_busy", busy, 1'b0);
                    check("rst_done", frame_done, 1'b0);
                    check("rst_err", frame_err, 1'b0);
                end
                tick();
                reset = 1'b0;
            end
            href = 1'b0;
            data = 8'h00;
            if (l == f_nlines - 1 && f_sim_vs) vsync = 1'b1;
            repeat (3) tick();
        end
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy; i++) tick();
        check({name, "_busy"}, busy, 1'b0);
    endtask

    task automatic compare_frame(input string name, input int exp_done);
        int n;
        wait_idle(name);
        check({name, "_nwr"}, mon_addr.size(), exp_addr.size());
        n = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", name, i), mon_addr[i], exp_addr[i]);
            check($sformatf("%s_data%0d", name, i), mon_data[i], exp_data[i]);
        end
        check({name, "_done"}, done_cnt, exp_done);
        check({name, "_err"}, frame_err, exp_err);
    endtask

    task automatic run_frame(input string name);
        clear_mon();
        compute_expected();
        arm(1'b0);
        drive_frame();
        compare_frame(name, 1);
    endtask

    initial begin
        reset = 1'b1; shutter = 1'b0; href = 1'b0; vsync = 1'b0; data = 8'h00;
        repeat (3) tick();
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_err", frame_err, 1'b0);
        check("reset_addr", wr_addr, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Basic two-line frame with known bytes
        set_frame(2, BPL, BPL, 0);
        run_frame("basic");
        if (mon_data.size() == 8) begin
            check("basic_first_px", mon_data[0], 16'h0102);
            check("basic_last_px", mon_data[7], 16'h1718);
        end else begin
            check("basic_count8", mon_data.size(), 8);
        end

        // Shutter rises during line activity: nothing until the next frame boundary
        set_frame(2, BPL, BPL, 8'h40);
        clear_mon();
        f_sh_at = 2; f_sh_val = 1'b1;
        drive_frame();
        check("mid_nwr", mon_addr.size(), 0);
        check("mid_done", done_cnt, 0);
        check("mid_busy", busy, 1'b1);
        shutter = 1'b0;
        f_sh_at = -1;
        compute_expected();
        drive_frame();
        compare_frame("mid", 1);

        set_frame(2, 7, BPL, 8'h20);
        run_frame("odd_line");

        set_frame(1, BPL, BPL, 8'h60);
        run_frame("early");

        set_frame(1, BPL, BPL, 8'h70);
        f_sim_vs = 1'b1;
        run_frame("early_sim");

        set_frame(2, BPL, BPL, 8'h80);
        f_sim_vs = 1'b1;
        run_frame("full_sim");

        set_frame(2, BPL + 2, BPL + 3, 8'h90);
        run_frame("overflow");

        // Reset during capture after three writes
        set_frame(2, BPL, BPL, 8'hA0);
        f_reset_after = 3;
        clear_mon();
        compute_expected();
        arm(1'b0);
        drive_frame();
        repeat (4) tick();
        check("rstcap_nwr", mon_addr.size(), 3);
        check("rstcap_done", done_cnt, 0);
        check("rstcap_busy", busy, 1'b0);
        check("rstcap_err", frame_err, 1'b0);
        for (int i = 0; i < 3 && i < mon_addr.size(); i++) begin
            check($sformatf("rstcap_addr%0d", i), mon_addr[i], exp_addr[i]);
            check($sformatf("rstcap_data%0d", i), mon_data[i], exp_data[i]);
        end

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            int nl, l0, l1;
            nl = ($urandom_range(0, 3) == 0) ? 1 : 2;
            l0 = ($urandom_range(0, 2) != 0) ? BPL : $urandom_range(1, BPL + 3);
            l1 = ($urandom_range(0, 2) != 0) ? BPL : $urandom_range(1, BPL + 3);
            set_frame(nl, l0, l1, -1);
            f_sim_vs = 1'($urandom_range(0, 1));
            run_frame($sformatf("rnd%0d", k));
        end

        // Shutter held across two frames
        set_frame(2, BPL, BPL, 8'hB0);
        clear_mon();
        arm(1'b1);
        drive_frame();
`ifdef CAPTURE_CONTINUOUS_EN
        check("cont_busy_between", busy, 1'b1);
        f_sh_at = 1; f_sh_val = 1'b0;
        drive_frame();
        compute_expected();
        for (int i = 0; i < N; i++) begin
            exp_addr.push_back(exp_addr[i]);
            exp_data.push_back(exp_data[i]);
        end
        compare_frame("cont", 2);
`else
        drive_frame();
        shutter = 1'b0;
        compute_expected();
        compare_frame("oneshot", 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/camera_capture_ctrl.md
Name: camera_capture_ctrl

Overview:
- Sequences single-frame capture from the camera byte stream (href/vsync/8-bit RGB565 bytes) on a shutter request.
- Assembles byte pairs into 16-bit pixels and issues linear write addresses to the frame buffer.
- Sits between the camera I/O block and the frame-buffer memory.
- Reports completion and geometry errors to software/LEDs.

Parameters:
- H_PIXELS, 320, pixels per line (2 bytes each)
- V_LINES, 240, lines per frame
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES

Ports:
- clk  in  1  25 MHz system clock
- reset  in  1  asynchronous, active-high reset
- shutter  in  1  raw shutter request (switch level, asynchronous)
- href  in  1  line-valid from camera I/O
- vsync  in  1  frame sync from camera I/O (high = vertical blanking)
- data  in  8  RGB565 byte, valid while href=1
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  pixel address, 0..H_PIXELS*V_LINES-1
- wr_data  out  16  assembled pixel {first byte, second byte}
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of a captured frame
- frame_err  out  1  sticky geometry error; cleared on next arm

Behaviour:
- Reset (async, active-high): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0; sync flops, byte phase and counters cleared. Reset mid-frame aborts with no further writes.
- shutter passes through a 2-FF synchronizer. A rise is detected on the synchronized signal (3rd flop).
- States:
  - IDLE: on shutter rise -> ARM; clear frame_err, wr_addr, line/byte counters.
  - ARM: wait for vsync=1 -> VBLANK. Guarantees capture starts at a frame boundary, never mid-frame.
  - VBLANK: on vsync falling edge (registered 1->0) -> CAPTURE.
  - CAPTURE: while href=1, byte phase toggles each cycle.
    - Phase 0 latches the high byte.
    - Phase 1 forms the pixel.
    - The pixel is registered onto wr_data with wr_en=1 in the cycle after phase-1 sampling (latency 1).
    - wr_addr holds the address of the current write and increments after each write.
  - DONE: assert frame_done for exactly one cycle -> IDLE.
- Line end: on href falling edge:
  - Phase resets to 0 and the line counter increments.
  - If the byte count for the line != 2*H_PIXELS, set frame_err. The byte count resets each line.
- Odd byte count: dangling phase-0 byte is discarded, no write, frame_err=1.
- Frame end, either event -> DONE:
  - line counter reaches V_LINES (normal); or
  - vsync rises during CAPTURE (early end).
  - Early end with lines < V_LINES also sets frame_err.
- Overflow: writes when wr_addr would reach H_PIXELS*V_LINES are suppressed (wr_en stays 0) and frame_err=1. No address wrap.
- Shutter rises while busy are ignored; no queuing.
- href ignored outside CAPTURE.
- Simultaneous vsync rise and final href fall: the line counts first, then DONE. frame_err reflects the line count including that line.
- frame_err holds through DONE and IDLE until the next arm.

Optional Feature:
- CAPTURE_CONTINUOUS_EN
  - Defined: from DONE, if synchronized shutter is still high, go to VBLANK (not IDLE). Capture continues frame after frame, wr_addr restarts at 0, frame_done pulses per frame, frame_err clears per frame. Releasing shutter finishes the current frame then returns to IDLE.
  - Undefined: strictly one-shot; each capture needs a new shutter rise.

Test Plan:
- H_PIXELS=4, V_LINES=2: shutter rise, vsync pulse, then 2 lines of 8 bytes 0x01..0x08 / 0x11..0x18 -> 8 writes, addr 0..7, data 0x0102,0x0304,...,0x1718; frame_done one pulse; frame_err=0; busy drops after done.
- Shutter rise mid-frame (during href activity) -> no writes until next vsync high->low; then full frame captured from addr 0.
- Line of 7 bytes -> 3 writes for that line, frame_err=1, capture continues, frame_done still pulses.
- vsync rises after 1 of 2 lines -> DONE early, 4 writes, frame_err=1.
- Assert reset during CAPTURE after 3 writes -> all outputs 0 immediately (async), state IDLE, no further wr_en.
- With CAPTURE_CONTINUOUS_EN and shutter held high for 2 frames -> 16 writes total, wr_addr restarts at 0 for frame 2, two frame_done pulses; release shutter -> IDLE after frame 2.
